// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, debug-loaded instruction memory, next-PC select
// and the IF/ID latch with stall, flush and sticky halt handling.
module fetch_stage #(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned NB_ADDR   = 7,
    parameter int unsigned NB_PC_SRC = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_pc_write,
    input  logic                 i_IF_ID_write,
    input  logic                 i_branch_or_jump,
    input  logic [NB_PC_SRC-1:0] i_pc_src,
    input  logic [NB_ADDR-1:0]   i_addr_branch,
    input  logic [NB_ADDR-1:0]   i_addr_jump,
    input  logic [NB_ADDR-1:0]   i_addr_register,
    input  logic                 i_halt,
    input  logic                 i_wr_mem,
    input  logic [NB_ADDR-1:0]   i_wr_addr,
    input  logic [NB_DATA-1:0]   i_wr_data,
    output logic [NB_DATA-1:0]   o_instruction,
    output logic [NB_ADDR-1:0]   o_pc,
    output logic [NB_ADDR-1:0]   o_pc_current,
    output logic                 o_halted
);

    localparam int unsigned DEPTH = 1 << NB_ADDR;

    localparam logic [NB_PC_SRC-1:0] SRC_BRANCH   = NB_PC_SRC'(1);
    localparam logic [NB_PC_SRC-1:0] SRC_JUMP     = NB_PC_SRC'(2);
    localparam logic [NB_PC_SRC-1:0] SRC_REGISTER = NB_PC_SRC'(3);

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_ADDR-1:0] r_pc;
    logic [NB_ADDR-1:0] r_if_id_pc;
    logic [NB_DATA-1:0] r_instruction;
    logic               r_halted;

    logic [NB_ADDR-1:0] w_pc_plus_1;
    logic [NB_ADDR-1:0] w_pc_next;
    logic [NB_DATA-1:0] w_fetch;
    logic               w_flush;

    // Memory has no reset so the debug-loaded program survives a pipeline reset.
    always_ff @(posedge i_clock) begin
        if (i_wr_mem) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_fetch     = r_mem[r_pc];
    assign w_pc_plus_1 = r_pc + NB_ADDR'(1);
    assign w_flush     = i_pc_write & i_branch_or_jump;

    always_comb begin
        w_pc_next = w_pc_plus_1;
        if (i_branch_or_jump) begin
            case (i_pc_src)
                SRC_BRANCH:   w_pc_next = i_addr_branch;
                SRC_JUMP:     w_pc_next = i_addr_jump;
                SRC_REGISTER: w_pc_next = i_addr_register;
                default:      w_pc_next = w_pc_plus_1;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pc          <= '0;
            r_if_id_pc    <= '0;
            r_instruction <= '0;
            r_halted      <= 1'b0;
        end else if (!r_halted && i_enable) begin
            if (i_halt) begin
                r_halted <= 1'b1;
            end else begin
                if (i_pc_write) begin
                    r_pc <= w_pc_next;
                end
                // A taken redirect squashes the wrong-path word with a NOP bubble.
                if (w_flush) begin
                    r_instruction <= '0;
                    r_if_id_pc    <= w_pc_plus_1;
                end else if (i_IF_ID_write) begin
                    r_instruction <= w_fetch;
                    r_if_id_pc    <= w_pc_plus_1;
                end
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc          = r_if_id_pc;
    assign o_pc_current  = r_pc;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table driven through a scoreboard queue, plus hand-written
// halt, debug-write and asynchronous-reset sequences.
module tb_fetch_stage;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_pc_write;
    logic        i_IF_ID_write;
    logic        i_branch_or_jump;
    logic [1:0]  i_pc_src;
    logic [6:0]  i_addr_branch;
    logic [6:0]  i_addr_jump;
    logic [6:0]  i_addr_register;
    logic        i_halt;
    logic        i_wr_mem;
    logic [6:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic [31:0] o_instruction;
    logic [6:0]  o_pc;
    logic [6:0]  o_pc_current;
    logic        o_halted;

    fetch_stage #(
        .NB_DATA   (32),
        .NB_ADDR   (7),
        .NB_PC_SRC (2)
    ) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_enable         (i_enable),
        .i_pc_write       (i_pc_write),
        .i_IF_ID_write    (i_IF_ID_write),
        .i_branch_or_jump (i_branch_or_jump),
        .i_pc_src         (i_pc_src),
        .i_addr_branch    (i_addr_branch),
        .i_addr_jump      (i_addr_jump),
        .i_addr_register  (i_addr_register),
        .i_halt           (i_halt),
        .i_wr_mem         (i_wr_mem),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_pc_current     (o_pc_current),
        .o_halted         (o_halted)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        en;
        logic        pcw;
        logic        ifw;
        logic        boj;
        logic [1:0]  src;
        logic [6:0]  ab;
        logic [6:0]  aj;
        logic [6:0]  ar;
        logic        halt;
        logic [31:0] exp_instr;
        logic [6:0]  exp_pc;
        logic [6:0]  exp_cur;
        logic        exp_halted;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem_img [128];
    vec_t        exp_q [$];
    vec_t        table_v [$];
    int          step_no  = 0;

    // Selected target goes to the input named by src; the other two carry decoys.
    function automatic vec_t mk(logic en, logic pcw, logic ifw, logic boj, logic [1:0] src,
                                logic [6:0] tgt, logic halt, logic [31:0] ei, logic [6:0] ep,
                                logic [6:0] ec, logic eh);
        vec_t v;
        v.en = en; v.pcw = pcw; v.ifw = ifw; v.boj = boj; v.src = src; v.halt = halt;
        v.ab = (src == 2'd1) ? tgt : tgt + 7'd50;
        v.aj = (src == 2'd2) ? tgt : tgt + 7'd90;
        v.ar = (src == 2'd3) ? tgt : tgt + 7'd17;
        v.exp_instr = ei; v.exp_pc = ep; v.exp_cur = ec; v.exp_halted = eh;
        return v;
    endfunction

    function automatic vec_t nrm(logic [31:0] ei, logic [6:0] ep, logic [6:0] ec, logic eh);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0, ei, ep, ec, eh);
    endfunction

    function automatic vec_t redir(logic [1:0] src, logic [6:0] tgt, logic [6:0] ep);
        return mk(1'b1, 1'b1, 1'b1, 1'b1, src, tgt, 1'b0, 32'd0, ep, tgt, 1'b0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        i_enable = 1'b1; i_pc_write = 1'b1; i_IF_ID_write = 1'b1; i_branch_or_jump = 1'b0;
        i_pc_src = 2'd0; i_addr_branch = '0; i_addr_jump = '0; i_addr_register = '0;
        i_halt = 1'b0;
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        i_enable = v.en; i_pc_write = v.pcw; i_IF_ID_write = v.ifw;
        i_branch_or_jump = v.boj; i_pc_src = v.src; i_addr_branch = v.ab;
        i_addr_jump = v.aj; i_addr_register = v.ar; i_halt = v.halt;
        exp_q.push_back(v);
        @(posedge i_clock);
        #1;
        e = exp_q.pop_front();
        check($sformatf("step%0d instr", step_no), o_instruction, e.exp_instr);
        check($sformatf("step%0d pc", step_no), 32'(o_pc), 32'(e.exp_pc));
        check($sformatf("step%0d pc_cur", step_no), 32'(o_pc_current), 32'(e.exp_cur));
        check($sformatf("step%0d halted", step_no), 32'(o_halted), 32'(e.exp_halted));
        step_no++;
    endtask

    // Reset is asserted between edges and the outputs must clear with no clock edge.
    task automatic async_reset(string tag);
        #2 i_reset = 1'b0;
        #1;
        check({tag, " rst instr"}, o_instruction, 32'd0);
        check({tag, " rst pc"}, 32'(o_pc), 32'd0);
        check({tag, " rst pc_cur"}, 32'(o_pc_current), 32'd0);
        check({tag, " rst halted"}, 32'(o_halted), 32'd0);
        set_idle();
        @(posedge i_clock);
        #1 i_reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 128; k++) mem_img[k] = 32'hA000_0000 + 32'(k);
        mem_img[0] = 32'h2001_0001;
        mem_img[1] = 32'h2002_0002;
        mem_img[2] = 32'h2003_0003;
        mem_img[3] = 32'h0000_0000;

        set_idle();
        i_reset = 1'b0; i_wr_mem = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        #1;
        for (int k = 0; k < 128; k++) begin
            i_wr_mem = 1'b1; i_wr_addr = 7'(k); i_wr_data = mem_img[k];
            @(posedge i_clock);
            #1;
        end
        i_wr_mem = 1'b0;
        check("reset instr", o_instruction, 32'd0);
        check("reset pc", 32'(o_pc), 32'd0);
        check("reset pc_cur", 32'(o_pc_current), 32'd0);
        check("reset halted", 32'(o_halted), 32'd0);
        i_reset = 1'b1;

        table_v.push_back(nrm(mem_img[0], 7'd1, 7'd1, 1'b0));
        table_v.push_back(nrm(mem_img[1], 7'd2, 7'd2, 1'b0));
        table_v.push_back(nrm(mem_img[2], 7'd3, 7'd3, 1'b0));
        table_v.push_back(nrm(mem_img[3], 7'd4, 7'd4, 1'b0));
        table_v.push_back(nrm(mem_img[4], 7'd5, 7'd5, 1'b0));
        table_v.push_back(mk(1, 0, 0, 0, 2'd0, 7'd0, 0, mem_img[4], 7'd5, 7'd5, 0));
        table_v.push_back(mk(1, 0, 0, 0, 2'd0, 7'd0, 0, mem_img[4], 7'd5, 7'd5, 0));
        table_v.push_back(nrm(mem_img[5], 7'd6, 7'd6, 1'b0));
        table_v.push_back(nrm(mem_img[6], 7'd7, 7'd7, 1'b0));
        table_v.push_back(nrm(mem_img[7], 7'd8, 7'd8, 1'b0));
        table_v.push_back(redir(2'd1, 7'd20, 7'd9));
        table_v.push_back(nrm(mem_img[20], 7'd21, 7'd21, 1'b0));
        table_v.push_back(redir(2'd2, 7'd40, 7'd22));
        table_v.push_back(nrm(mem_img[40], 7'd41, 7'd41, 1'b0));
        table_v.push_back(redir(2'd3, 7'd3, 7'd42));
        table_v.push_back(nrm(mem_img[3], 7'd4, 7'd4, 1'b0));
        table_v.push_back(mk(1, 0, 0, 1, 2'd1, 7'd100, 0, mem_img[3], 7'd4, 7'd4, 0));
        table_v.push_back(nrm(mem_img[4], 7'd5, 7'd5, 1'b0));
        table_v.push_back(mk(1, 1, 1, 1, 2'd0, 7'd99, 0, 32'd0, 7'd6, 7'd6, 0));
        table_v.push_back(mk(0, 1, 1, 0, 2'd0, 7'd0, 1, 32'd0, 7'd6, 7'd6, 0));
        table_v.push_back(nrm(mem_img[6], 7'd7, 7'd7, 1'b0));
        table_v.push_back(redir(2'd2, 7'd126, 7'd8));
        table_v.push_back(nrm(mem_img[126], 7'd127, 7'd127, 1'b0));
        table_v.push_back(nrm(mem_img[127], 7'd0, 7'd0, 1'b0));
        table_v.push_back(redir(2'd2, 7'd12, 7'd1));
        table_v.push_back(mk(1, 1, 1, 0, 2'd0, 7'd0, 1, 32'd0, 7'd1, 7'd12, 1));
        foreach (table_v[i]) apply(table_v[i]);

        // Halted: everything frozen while a debug write still lands.
        i_wr_mem = 1'b1; i_wr_addr = 7'd12; i_wr_data = 32'hFFFF_FFFF;
        apply(nrm(32'd0, 7'd1, 7'd12, 1'b1));
        i_wr_mem = 1'b0;
        mem_img[12] = 32'hFFFF_FFFF;
        apply(mk(0, 1, 1, 0, 2'd0, 7'd0, 0, 32'd0, 7'd1, 7'd12, 1));
        apply(mk(1, 1, 1, 0, 2'd0, 7'd0, 1, 32'd0, 7'd1, 7'd12, 1));
        apply(mk(1, 1, 1, 1, 2'd2, 7'd50, 0, 32'd0, 7'd1, 7'd12, 1));
        async_reset("halted");

        apply(redir(2'd2, 7'd29, 7'd1));
        apply(nrm(mem_img[29], 7'd30, 7'd30, 1'b0));
        async_reset("pc30");

        // Memory survives reset; a same-cycle write at PC latches the old word.
        apply(redir(2'd2, 7'd12, 7'd1));
        i_wr_mem = 1'b1; i_wr_addr = 7'd12; i_wr_data = 32'h1234_5678;
        apply(nrm(32'hFFFF_FFFF, 7'd13, 7'd13, 1'b0));
        i_wr_mem = 1'b0;
        apply(redir(2'd1, 7'd12, 7'd14));
        apply(nrm(32'h1234_5678, 7'd13, 7'd13, 1'b0));
        apply(redir(2'd3, 7'd29, 7'd14));
        apply(nrm(mem_img[29], 7'd30, 7'd30, 1'b0));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
